// File: rtl/ad9361_spi_sequencer_if.sv
// Command/response and SPI-master-core register bus of the AD9361 SPI sequencer.
// The slave modport is the sequencer's view; master is the host plus SPI core side.
interface ad9361_spi_sequencer_if;
    logic        cmd_valid;
    logic        cmd_ready;
    logic        cmd_write;
    logic [9:0]  cmd_addr;
    logic [7:0]  cmd_wdata;
    logic        rsp_valid;
    logic [7:0]  rsp_rdata;
    logic        rsp_err;
    logic        busy;
    logic        spi_select;
    logic [2:0]  mem_addr;
    logic [15:0] data_to_spi;
    logic        read_n;
    logic        write_n;
    logic [15:0] data_from_spi;
    logic        spi_readyfordata;
    logic        spi_dataavailable;

    modport slave (
        input  cmd_valid, cmd_write, cmd_addr, cmd_wdata,
        input  data_from_spi, spi_readyfordata, spi_dataavailable,
        output cmd_ready, rsp_valid, rsp_rdata, rsp_err, busy,
        output spi_select, mem_addr, data_to_spi, read_n, write_n
    );

    modport master (
        output cmd_valid, cmd_write, cmd_addr, cmd_wdata,
        output data_from_spi, spi_readyfordata, spi_dataavailable,
        input  cmd_ready, rsp_valid, rsp_rdata, rsp_err, busy,
        input  spi_select, mem_addr, data_to_spi, read_n, write_n
    );
endinterface

// File: rtl/ad9361_spi_sequencer.sv
// Turns one AD9361 register read/write into the 24-bit SPI transfer on an SPI master core.
// Optional per-wait watchdog: define AD9361_SPI_TIMEOUT_EN.
module ad9361_spi_sequencer #(
    parameter int TIMEOUT_CYCLES = 4096
) (
    input  logic                    clk,
    input  logic                    reset_n,
    ad9361_spi_sequencer_if.slave   bus
);

    typedef enum logic [3:0] {
        IDLE, CLR_STS, SS_WR, CTL_ON, TX_WAIT, TX_WR, RX_WAIT, RX_RD, CTL_OFF, RESP
    } state_t;

    state_t      state_q, state_d;
    logic [1:0]  phase_q, phase_d;
    logic [1:0]  byte_idx_q, byte_idx_d;
    logic        cmd_write_q, cmd_write_d;
    logic [9:0]  cmd_addr_q, cmd_addr_d;
    logic [7:0]  cmd_wdata_q, cmd_wdata_d;
    logic [7:0]  rsp_rdata_q, rsp_rdata_d;
    logic [7:0]  tx_byte;
    logic        unused_rd_hi;

`ifdef AD9361_SPI_TIMEOUT_EN
    localparam int CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    logic [CNT_W-1:0] wait_cnt_q, wait_cnt_d;
    logic             err_q, err_d;
    logic             wait_expired;

    assign wait_expired = (wait_cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));
`endif

    assign unused_rd_hi = ^bus.data_from_spi[15:8];

    always_comb begin
        tx_byte = 8'h00;
        case (byte_idx_q)
            2'd0:    tx_byte = {cmd_write_q, 2'b00, 3'b000, cmd_addr_q[9:8]};
            2'd1:    tx_byte = cmd_addr_q[7:0];
            default: tx_byte = cmd_write_q ? cmd_wdata_q : 8'h00;
        endcase
    end

    // phase 0/1 are the two strobe cycles of an access, phase 2 is the gap
    // needed only when the next state is itself an access.
    always_comb begin
        state_d     = state_q;
        phase_d     = phase_q;
        byte_idx_d  = byte_idx_q;
        cmd_write_d = cmd_write_q;
        cmd_addr_d  = cmd_addr_q;
        cmd_wdata_d = cmd_wdata_q;
        rsp_rdata_d = rsp_rdata_q;
`ifdef AD9361_SPI_TIMEOUT_EN
        wait_cnt_d  = wait_cnt_q;
        err_d       = err_q;
`endif
        case (state_q)
            IDLE: begin
                if (bus.cmd_valid) begin
                    cmd_write_d = bus.cmd_write;
                    cmd_addr_d  = bus.cmd_addr;
                    cmd_wdata_d = bus.cmd_wdata;
                    byte_idx_d  = 2'd0;
                    phase_d     = 2'd0;
                    state_d     = CLR_STS;
`ifdef AD9361_SPI_TIMEOUT_EN
                    err_d       = 1'b0;
`endif
                end
            end
            CLR_STS, SS_WR: begin
                if (phase_q == 2'd2) begin
                    phase_d = 2'd0;
                    state_d = (state_q == CLR_STS) ? SS_WR : CTL_ON;
                end else begin
                    phase_d = phase_q + 2'd1;
                end
            end
            CTL_ON, TX_WR: begin
                if (phase_q == 2'd1) begin
                    phase_d = 2'd0;
                    state_d = (state_q == CTL_ON) ? TX_WAIT : RX_WAIT;
`ifdef AD9361_SPI_TIMEOUT_EN
                    wait_cnt_d = '0;
`endif
                end else begin
                    phase_d = phase_q + 2'd1;
                end
            end
            TX_WAIT, RX_WAIT: begin
                if ((state_q == TX_WAIT) ? bus.spi_readyfordata : bus.spi_dataavailable) begin
                    phase_d = 2'd0;
                    state_d = (state_q == TX_WAIT) ? TX_WR : RX_RD;
`ifdef AD9361_SPI_TIMEOUT_EN
                end else if (wait_expired) begin
                    phase_d = 2'd0;
                    err_d   = 1'b1;
                    state_d = CTL_OFF;
                end else begin
                    wait_cnt_d = wait_cnt_q + 1'b1;
`endif
                end
            end
            RX_RD: begin
                if (phase_q == 2'd0) begin
                    phase_d = 2'd1;
                end else if (phase_q == 2'd1) begin
                    if (byte_idx_q == 2'd2) begin
                        if (!cmd_write_q) begin
                            rsp_rdata_d = bus.data_from_spi[7:0];
                        end
                        phase_d = 2'd2;
                    end else begin
                        byte_idx_d = byte_idx_q + 2'd1;
                        phase_d    = 2'd0;
                        state_d    = TX_WAIT;
`ifdef AD9361_SPI_TIMEOUT_EN
                        wait_cnt_d = '0;
`endif
                    end
                end else begin
                    phase_d = 2'd0;
                    state_d = CTL_OFF;
                end
            end
            CTL_OFF: begin
                if (phase_q == 2'd1) begin
                    phase_d = 2'd0;
                    state_d = RESP;
                end else begin
                    phase_d = phase_q + 2'd1;
                end
            end
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        bus.spi_select  = 1'b0;
        bus.write_n     = 1'b1;
        bus.read_n      = 1'b1;
        bus.mem_addr    = 3'd0;
        bus.data_to_spi = 16'h0000;
        if (phase_q != 2'd2) begin
            case (state_q)
                CLR_STS: begin
                    bus.spi_select = 1'b1; bus.write_n = 1'b0;
                    bus.mem_addr = 3'd2;   bus.data_to_spi = 16'h0000;
                end
                SS_WR: begin
                    bus.spi_select = 1'b1; bus.write_n = 1'b0;
                    bus.mem_addr = 3'd5;   bus.data_to_spi = 16'h0001;
                end
                CTL_ON: begin
                    bus.spi_select = 1'b1; bus.write_n = 1'b0;
                    bus.mem_addr = 3'd3;   bus.data_to_spi = 16'h0400;
                end
                TX_WR: begin
                    bus.spi_select = 1'b1; bus.write_n = 1'b0;
                    bus.mem_addr = 3'd1;   bus.data_to_spi = {8'h00, tx_byte};
                end
                RX_RD: begin
                    bus.spi_select = 1'b1; bus.read_n = 1'b0;
                    bus.mem_addr = 3'd0;
                end
                CTL_OFF: begin
                    bus.spi_select = 1'b1; bus.write_n = 1'b0;
                    bus.mem_addr = 3'd3;   bus.data_to_spi = 16'h0000;
                end
                default: ;
            endcase
        end
    end

    assign bus.cmd_ready = (state_q == IDLE);
    assign bus.busy      = (state_q != IDLE);
    assign bus.rsp_valid = (state_q == RESP);
    assign bus.rsp_rdata = rsp_rdata_q;
`ifdef AD9361_SPI_TIMEOUT_EN
    assign bus.rsp_err   = (state_q == RESP) && err_q;
`else
    assign bus.rsp_err   = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q     <= IDLE;
            phase_q     <= 2'd0;
            byte_idx_q  <= 2'd0;
            cmd_write_q <= 1'b0;
            cmd_addr_q  <= 10'd0;
            cmd_wdata_q <= 8'h00;
            rsp_rdata_q <= 8'h00;
`ifdef AD9361_SPI_TIMEOUT_EN
            wait_cnt_q  <= '0;
            err_q       <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            phase_q     <= phase_d;
            byte_idx_q  <= byte_idx_d;
            cmd_write_q <= cmd_write_d;
            cmd_addr_q  <= cmd_addr_d;
            cmd_wdata_q <= cmd_wdata_d;
            rsp_rdata_q <= rsp_rdata_d;
`ifdef AD9361_SPI_TIMEOUT_EN
            wait_cnt_q  <= wait_cnt_d;
            err_q       <= err_d;
`endif
        end
    end

endmodule

// File: tb/tb_ad9361_spi_sequencer.sv
// Self-checking bench for ad9361_spi_sequencer with a behavioural SPI master core model.
// Build with AD9361_SPI_TIMEOUT_EN defined to exercise the watchdog path instead of the stall path.
module tb_ad9361_spi_sequencer;

    localparam int TO_CYCLES = 16;
    localparam int SHIFT_CYCLES = 6;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    always #5 clk = ~clk;

    ad9361_spi_sequencer_if bus();

    ad9361_spi_sequencer #(.TIMEOUT_CYCLES(TO_CYCLES)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    typedef struct {
        logic        wr;
        logic [2:0]  addr;
        logic [15:0] data;
    } acc_t;

    typedef struct {
        logic        wr;
        logic [9:0]  addr;
        logic [7:0]  wdata;
        logic [7:0]  sb2;
        logic [7:0]  b0;
        logic [7:0]  b1;
        logic [7:0]  b2;
        logic [7:0]  exp_rdata;
    } vec_t;

    acc_t access_log[$];

    // SPI master core model state
    logic       trdy, rrdy, sso, force_trdy_low;
    logic [7:0] rx_byte, rx_next;
    logic [7:0] slave_bytes [3];
    int         shift_cnt, tx_idx, mdl_phase;
    int         ss_violations = 0;

    // protocol monitor state
    int         proto_err = 0;
    int         run_len = 0;
    int         gap_len = 0;
    int         ctl_off_gap = 0;
    logic [2:0] prev_addr = 3'd0;

    int checks = 0;
    int passes = 0;

    assign bus.spi_readyfordata  = trdy & ~force_trdy_low;
    assign bus.spi_dataavailable = rrdy;
    assign bus.data_from_spi     = (bus.mem_addr == 3'd0) ? {8'hC3, rx_byte} : 16'h0000;

    // Core model: an access commits at the edge ending its second strobe cycle.
    always @(posedge clk) begin
        if (!reset_n) begin
            trdy      <= 1'b1;
            rrdy      <= 1'b0;
            sso       <= 1'b0;
            rx_byte   <= 8'h00;
            rx_next   <= 8'h00;
            shift_cnt <= 0;
            tx_idx    <= 0;
            mdl_phase <= 0;
        end else begin
            if (shift_cnt != 0) begin
                shift_cnt <= shift_cnt - 1;
                if (shift_cnt == 1) begin
                    trdy    <= 1'b1;
                    rrdy    <= 1'b1;
                    rx_byte <= rx_next;
                end
            end
            if (bus.spi_select && (!bus.write_n || !bus.read_n)) begin
                mdl_phase <= mdl_phase + 1;
                if (mdl_phase == 1) begin
                    if (!bus.write_n) begin
                        access_log.push_back('{1'b1, bus.mem_addr, bus.data_to_spi});
                        case (bus.mem_addr)
                            3'd1: begin
                                trdy      <= 1'b0;
                                shift_cnt <= SHIFT_CYCLES;
                                rx_next   <= (tx_idx < 3) ? slave_bytes[tx_idx] : 8'h00;
                                tx_idx    <= tx_idx + 1;
                                if (!sso) ss_violations <= ss_violations + 1;
                            end
                            3'd3: sso <= bus.data_to_spi[10];
                            3'd5: tx_idx <= 0;
                            default: ;
                        endcase
                    end else begin
                        access_log.push_back('{1'b0, bus.mem_addr, 16'h0000});
                        if (bus.mem_addr == 3'd0) rrdy <= 1'b0;
                    end
                end
            end else begin
                mdl_phase <= 0;
            end
        end
    end

    // Access shape monitor, sampled on the falling edge.
    always @(negedge clk) begin
        if (!reset_n) begin
            run_len <= 0;
            gap_len <= 0;
        end else begin
            if (!bus.read_n && !bus.write_n) begin
                proto_err <= proto_err + 1;
                $display("[TB] protocol violation: read_n and write_n low together at %0t", $time);
            end
            if (bus.spi_select && (!bus.write_n || !bus.read_n)) begin
                run_len   <= run_len + 1;
                prev_addr <= bus.mem_addr;
                if (run_len >= 2) begin
                    proto_err <= proto_err + 1;
                    $display("[TB] protocol violation: access longer than 2 cycles at %0t", $time);
                end
                if (run_len == 1 && bus.mem_addr != prev_addr) begin
                    proto_err <= proto_err + 1;
                    $display("[TB] protocol violation: mem_addr changed mid-access at %0t", $time);
                end
                if (run_len == 0) begin
                    if (bus.mem_addr == 3'd3 && bus.data_to_spi == 16'h0000 && !bus.write_n)
                        ctl_off_gap <= gap_len;
                    gap_len <= 0;
                end
            end else begin
                if (run_len == 1) begin
                    proto_err <= proto_err + 1;
                    $display("[TB] protocol violation: 1-cycle access at %0t", $time);
                end
                run_len <= 0;
                gap_len <= bus.busy ? gap_len + 1 : 0;
            end
        end
    end

    initial begin
        #500000;
        $display("[TB] FAIL global_timeout: simulation still running at %0t, required to finish earlier", $time);
        $fatal(1, "[TB] global timeout");
    end

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual === expected) passes++;
        else $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    endtask

    function automatic logic [31:0] packAcc(input acc_t a);
        return {11'b0, a.wr, 1'b0, a.addr, a.data};
    endfunction

    function automatic acc_t mkAcc(input logic wr, input logic [2:0] addr, input logic [15:0] data);
        acc_t a;
        a.wr = wr; a.addr = addr; a.data = data;
        return a;
    endfunction

    task automatic checkResetState(input string tag);
        checkOutput({tag, "_cmd_ready"},   bus.cmd_ready,   1);
        checkOutput({tag, "_busy"},        bus.busy,        0);
        checkOutput({tag, "_rsp_valid"},   bus.rsp_valid,   0);
        checkOutput({tag, "_rsp_err"},     bus.rsp_err,     0);
        checkOutput({tag, "_rsp_rdata"},   bus.rsp_rdata,   0);
        checkOutput({tag, "_spi_select"},  bus.spi_select,  0);
        checkOutput({tag, "_read_n"},      bus.read_n,      1);
        checkOutput({tag, "_write_n"},     bus.write_n,     1);
        checkOutput({tag, "_mem_addr"},    bus.mem_addr,    0);
        checkOutput({tag, "_data_to_spi"}, bus.data_to_spi, 0);
    endtask

    task automatic checkSequence(input string name, input int base,
                                 input logic [7:0] b0, input logic [7:0] b1, input logic [7:0] b2);
        acc_t exp_seq [10];
        logic [31:0] act;
        exp_seq[0] = mkAcc(1'b1, 3'd2, 16'h0000);
        exp_seq[1] = mkAcc(1'b1, 3'd5, 16'h0001);
        exp_seq[2] = mkAcc(1'b1, 3'd3, 16'h0400);
        exp_seq[3] = mkAcc(1'b1, 3'd1, {8'h00, b0});
        exp_seq[4] = mkAcc(1'b0, 3'd0, 16'h0000);
        exp_seq[5] = mkAcc(1'b1, 3'd1, {8'h00, b1});
        exp_seq[6] = mkAcc(1'b0, 3'd0, 16'h0000);
        exp_seq[7] = mkAcc(1'b1, 3'd1, {8'h00, b2});
        exp_seq[8] = mkAcc(1'b0, 3'd0, 16'h0000);
        exp_seq[9] = mkAcc(1'b1, 3'd3, 16'h0000);
        checkOutput({name, "_num_accesses"}, access_log.size() - base, 10);
        for (int i = 0; i < 10; i++) begin
            act = (base + i < access_log.size()) ? packAcc(access_log[base + i]) : 32'hDEADBEEF;
            checkOutput($sformatf("%s_access%0d", name, i), act, packAcc(exp_seq[i]));
        end
    endtask

    task automatic applyStimulus(input string name, input logic wr, input logic [9:0] addr,
                                 input logic [7:0] wdata, input logic hold);
        logic ready_seen = 1'b0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (bus.cmd_ready) begin
                ready_seen = 1'b1;
                break;
            end
        end
        if (!ready_seen) checkOutput({name, "_cmd_ready_seen"}, 0, 1);
        bus.cmd_valid = 1'b1;
        bus.cmd_write = wr;
        bus.cmd_addr  = addr;
        bus.cmd_wdata = wdata;
        @(posedge clk);
        #1;
        if (!hold) bus.cmd_valid = 1'b0;
    endtask

    task automatic waitResponse(input string name, input int budget,
                                output logic err, output logic [7:0] rdata);
        logic got = 1'b0;
        err = 1'b0;
        rdata = 8'h00;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (bus.rsp_valid) begin
                got = 1'b1;
                err = bus.rsp_err;
                rdata = bus.rsp_rdata;
                break;
            end
        end
        checkOutput({name, "_rsp_seen"}, got, 1);
    endtask

    task automatic runVector(input string name, input vec_t v);
        int base;
        logic err;
        logic [7:0] rdata;
        slave_bytes[0] = 8'hEE;
        slave_bytes[1] = 8'hDD;
        slave_bytes[2] = v.sb2;
        base = access_log.size();
        applyStimulus(name, v.wr, v.addr, v.wdata, 1'b0);
        waitResponse(name, 3000, err, rdata);
        checkOutput({name, "_rsp_err"}, err, 0);
        checkOutput({name, "_rsp_rdata"}, rdata, v.exp_rdata);
        @(negedge clk);
        checkOutput({name, "_rsp_valid_one_cycle"}, bus.rsp_valid, 0);
        checkOutput({name, "_cmd_ready_after"}, bus.cmd_ready, 1);
        checkSequence(name, base, v.b0, v.b1, v.b2);
    endtask

    initial begin
        vec_t vecs [6];
        int base, base_b;
        logic err;
        logic [7:0] rdata;
        logic seen;

        vecs[0] = '{1'b1, 10'h3FF, 8'hA5, 8'h11, 8'h83, 8'hFF, 8'hA5, 8'h00};
        vecs[1] = '{1'b0, 10'h037, 8'hFF, 8'h5C, 8'h00, 8'h37, 8'h00, 8'h5C};
        vecs[2] = '{1'b1, 10'h000, 8'h3C, 8'h22, 8'h80, 8'h00, 8'h3C, 8'h5C};
        vecs[3] = '{1'b0, 10'h2A5, 8'h5A, 8'h81, 8'h02, 8'hA5, 8'h00, 8'h81};
        vecs[4] = '{1'b0, 10'h100, 8'h00, 8'h00, 8'h01, 8'h00, 8'h00, 8'h00};
        vecs[5] = '{1'b1, 10'h155, 8'hFF, 8'h33, 8'h81, 8'h55, 8'hFF, 8'h00};

        bus.cmd_valid = 1'b0;
        bus.cmd_write = 1'b0;
        bus.cmd_addr  = 10'd0;
        bus.cmd_wdata = 8'h00;
        force_trdy_low = 1'b0;
        slave_bytes[0] = 8'h00;
        slave_bytes[1] = 8'h00;
        slave_bytes[2] = 8'h00;

        repeat (3) @(negedge clk);
        checkResetState("reset");
        reset_n = 1'b1;

        for (int i = 0; i < 6; i++) runVector($sformatf("vec%0d", i), vecs[i]);

        // two commands with cmd_valid held high throughout
        slave_bytes[0] = 8'hEE;
        slave_bytes[1] = 8'hDD;
        slave_bytes[2] = 8'h9A;
        base = access_log.size();
        applyStimulus("b2b_a", 1'b1, 10'h2C3, 8'h11, 1'b1);
        bus.cmd_write = 1'b0;
        bus.cmd_addr  = 10'h0F0;
        bus.cmd_wdata = 8'h66;
        waitResponse("b2b_a", 3000, err, rdata);
        checkOutput("b2b_a_rsp_err", err, 0);
        checkOutput("b2b_a_rsp_rdata", rdata, 8'h00);
        @(negedge clk);
        checkOutput("b2b_idle_cycle_ready", bus.cmd_ready, 1);
        @(negedge clk);
        bus.cmd_valid = 1'b0;
        checkOutput("b2b_b_busy", bus.busy, 1);
        checkOutput("b2b_b_first_access",
                    {bus.spi_select, bus.write_n, bus.read_n, bus.mem_addr}, {1'b1, 1'b0, 1'b1, 3'd2});
        checkSequence("b2b_a", base, 8'h82, 8'hC3, 8'h11);
        base_b = base + 10;
        waitResponse("b2b_b", 3000, err, rdata);
        checkOutput("b2b_b_rsp_err", err, 0);
        checkOutput("b2b_b_rsp_rdata", rdata, 8'h9A);
        checkSequence("b2b_b", base_b, 8'h00, 8'hF0, 8'h00);

        // transmitter never becomes ready
        slave_bytes[2] = 8'h42;
        force_trdy_low = 1'b1;
        base = access_log.size();
        applyStimulus("stall", 1'b0, 10'h001, 8'h00, 1'b0);
`ifdef AD9361_SPI_TIMEOUT_EN
        waitResponse("timeout", 500, err, rdata);
        checkOutput("timeout_rsp_err", err, 1);
        checkOutput("timeout_rsp_rdata", rdata, 8'h9A);
        checkOutput("timeout_num_accesses", access_log.size() - base, 4);
        checkOutput("timeout_access0", packAcc(access_log[base + 0]), packAcc(mkAcc(1'b1, 3'd2, 16'h0000)));
        checkOutput("timeout_access1", packAcc(access_log[base + 1]), packAcc(mkAcc(1'b1, 3'd5, 16'h0001)));
        checkOutput("timeout_access2", packAcc(access_log[base + 2]), packAcc(mkAcc(1'b1, 3'd3, 16'h0400)));
        checkOutput("timeout_access3", packAcc(access_log[base + 3]), packAcc(mkAcc(1'b1, 3'd3, 16'h0000)));
        checkOutput("timeout_cycles_in_tx_wait", ctl_off_gap, TO_CYCLES);
        force_trdy_low = 1'b0;
        @(negedge clk);
        checkOutput("timeout_cmd_ready_after", bus.cmd_ready, 1);
`else
        seen = 1'b0;
        repeat (40) begin
            @(negedge clk);
            if (bus.rsp_valid) seen = 1'b1;
        end
        checkOutput("stall_no_rsp", seen, 0);
        checkOutput("stall_busy", bus.busy, 1);
        checkOutput("stall_num_accesses", access_log.size() - base, 3);
        force_trdy_low = 1'b0;
        waitResponse("stall", 3000, err, rdata);
        checkOutput("stall_rsp_err", err, 0);
        checkOutput("stall_rsp_rdata", rdata, 8'h42);
        checkSequence("stall", base, 8'h00, 8'h01, 8'h00);
`endif

        // reset pulse while waiting for the first received byte
        slave_bytes[2] = 8'hAB;
        base = access_log.size();
        applyStimulus("midrst", 1'b0, 10'h2FF, 8'h00, 1'b0);
        seen = 1'b0;
        for (int i = 0; i < 500; i++) begin
            @(negedge clk);
            if (access_log.size() >= base + 4) begin
                seen = 1'b1;
                break;
            end
        end
        checkOutput("midrst_reached_rx_wait", seen, 1);
        checkOutput("midrst_waiting_rx", {bus.busy, bus.spi_dataavailable}, 2'b10);
        reset_n = 1'b0;
        @(negedge clk);
        checkResetState("midrst");
        reset_n = 1'b1;
        seen = 1'b0;
        repeat (30) begin
            @(negedge clk);
            if (bus.rsp_valid) seen = 1'b1;
        end
        checkOutput("midrst_no_rsp", seen, 0);

        runVector("post_reset", '{1'b0, 10'h3C0, 8'h00, 8'h77, 8'h03, 8'hC0, 8'h00, 8'h77});

        repeat (3) @(negedge clk);
        checkOutput("protocol_violations", proto_err, 0);
        checkOutput("ss_violations", ss_violations, 0);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule

// File: doc/ad9361_spi_sequencer.md
AD9361_SPI_SEQUENCER -- requirements
Module: ad9361_spi_sequencer

Interface
REQ-001 SHALL have parameter TIMEOUT_CYCLES, default 4096, giving the per-wait watchdog limit in clk cycles.
REQ-002 SHALL have clk, input, 1: single clock shared with the SPI master core.
REQ-003 SHALL have reset_n, input, 1: reset, synchronous, active-low.
REQ-004 SHALL have cmd_valid, input, 1: command request.
REQ-005 SHALL have cmd_ready, output, 1: high only in IDLE.
REQ-006 SHALL have cmd_write, input, 1: 1 = register write, 0 = register read.
REQ-007 SHALL have cmd_addr, input, 10: AD9361 register address.
REQ-008 SHALL have cmd_wdata, input, 8: write data; ignored for reads.
REQ-009 SHALL have rsp_valid, output, 1: one-cycle completion pulse.
REQ-010 SHALL have rsp_rdata, output, 8: read data, held until the next rsp_valid.
REQ-011 SHALL have rsp_err, output, 1: timeout flag, qualified by rsp_valid.
REQ-012 SHALL have busy, output, 1: high whenever not in IDLE.
REQ-013 SHALL have spi_select, output, 1: chip select to the SPI master core.
REQ-014 SHALL have mem_addr, output, 3: SPI core register address.
REQ-015 SHALL have data_to_spi, output, 16: SPI core write data.
REQ-016 SHALL have read_n and write_n, outputs, 1 each: active-low access strobes.
REQ-017 SHALL have data_from_spi, input, 16: SPI core read data.
REQ-018 SHALL have spi_readyfordata and spi_dataavailable, inputs, 1 each: the core's TRDY and RRDY.

Function
REQ-019 SHALL hold every core access for exactly 2 cycles (spi_select plus write_n or read_n low, mem_addr stable), then deassert for at least 1 cycle.
REQ-020 SHALL sample data_from_spi at the clk edge that ends cycle 2 of a read access.
REQ-021 SHALL latch cmd_write, cmd_addr and cmd_wdata on the cycle where cmd_valid and cmd_ready are both high.
REQ-022 SHALL run the states in order: IDLE, CLR_STS (write addr 2, data 0), SS_WR (write addr 5, data 0x0001), CTL_ON (write addr 3, data 0x0400, SSO=1), then loops of TX_WAIT, TX_WR, RX_WAIT, RX_RD, then CTL_OFF (write addr 3, data 0x0000), RESP, IDLE.
REQ-023 SHALL loop TX_WAIT to RX_RD three times, with byte index 0, 1, 2.
REQ-024 SHALL stay in TX_WAIT until spi_readyfordata=1, then use TX_WR to write addr 1 with the byte in the low 8 bits and the upper 8 bits zero.
REQ-025 SHALL send the 16-bit instruction {cmd_write, 2'b00, 3'b000, cmd_addr}: byte 0 = [15:8], byte 1 = [7:0]; byte 2 = cmd_wdata for writes, 0x00 for reads.
REQ-026 SHALL stay in RX_WAIT until spi_dataavailable=1, then use RX_RD to read addr 0.
REQ-027 SHALL discard the data read for bytes 0 and 1, and load data_from_spi[7:0] into rsp_rdata for byte 2 of a read.
REQ-028 SHALL leave rsp_rdata unchanged on writes.
REQ-029 SHALL pulse rsp_valid for exactly 1 cycle in RESP; cmd_ready SHALL return high on the next cycle.
REQ-030 SHALL ignore cmd_valid while busy; a held cmd_valid SHALL be accepted on the first IDLE cycle.
REQ-031 SHALL deliver the minimum latency from accept to rsp_valid that follows from REQ-019 plus the core's wait time; no extra idle cycles SHALL be added beyond REQ-019.

Reset
REQ-032 On reset_n=0 at a clk edge, SHALL enter IDLE with cmd_ready=1, busy=0, rsp_valid=0, rsp_err=0, rsp_rdata=0x00, spi_select=0, read_n=1, write_n=1, mem_addr=0, data_to_spi=0.
REQ-033 Reset mid-transaction SHALL abandon the transaction with no rsp_valid; the SPI core is reset by the same reset_n.

Configuration
REQ-034 With AD9361_SPI_TIMEOUT_EN defined, a counter SHALL clear on entry to TX_WAIT or RX_WAIT and count each cycle waited.
REQ-035 With AD9361_SPI_TIMEOUT_EN defined, reaching TIMEOUT_CYCLES SHALL jump to CTL_OFF, then RESP with rsp_err=1 and rsp_rdata unchanged.
REQ-036 Without AD9361_SPI_TIMEOUT_EN, waits SHALL be unbounded, rsp_err SHALL be constant 0, and no counter SHALL be built.

Verification
REQ-037 Write cmd, addr 0x3FF, data 0xA5, behavioural SPI core model -> data-register writes 0x83, 0xFF, 0xA5 in order; SS stays low across all 24 bits; rsp_valid=1 with rsp_err=0.
REQ-038 Read cmd, addr 0x037, slave returns 0x5C on byte 2 -> writes 0x00, 0x37, 0x00; rsp_rdata=0x5C.
REQ-039 cmd_valid held high through 2 back-to-back commands -> the second is accepted the cycle after rsp_valid; the access ordering of REQ-022 is repeated exactly.
REQ-040 spi_readyfordata held 0, macro defined, TIMEOUT_CYCLES=16 -> CTL_OFF write 0x0000, then rsp_valid with rsp_err=1 at 16 cycles in TX_WAIT.
REQ-041 reset_n=0 for 1 cycle during RX_WAIT -> all outputs at REQ-032 values on the next cycle; no rsp_valid.
REQ-042 Protocol checker, all tests -> every access lasts exactly 2 cycles, is never back-to-back without a gap, and read_n and write_n are never low together.
